// File: rtl/spike_generator_array_pkg.sv
// Shared types and constants for the time-multiplexed spike generator array.
package spike_generator_array_pkg;

    localparam int N_GENS   = 8;
    localparam int N_PERIOD = 16;
    localparam int N_TAG    = 11;
    localparam int N_CT     = 9;

    // One generator's stored state: reload period, live countdown and tag.
    typedef struct packed {
        logic [N_PERIOD-1:0] period;
        logic [N_PERIOD-1:0] ticks;
        logic [N_TAG-1:0]    tag;
    } gen_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_EMIT
    } gen_state_t;

    // Every emitted word carries a count of exactly one spike.
    localparam logic [N_CT-1:0] CT_ONE = N_CT'(1);

endpackage

// File: rtl/spike_generator_array_if.sv
// Programming stream and tag/count output stream of the spike generator array.
// The master side is the host (decoder upstream, tag merge downstream);
// the slave side is the generator array itself.
interface spike_generator_array_if
    import spike_generator_array_pkg::*;
#(
    parameter int NGens   = N_GENS,
    parameter int NPeriod = N_PERIOD,
    parameter int NTag    = N_TAG,
    parameter int NCt     = N_CT
);

    logic [NGens-1:0]   prog_gen_idx;
    logic [NPeriod-1:0] prog_period;
    logic [NPeriod-1:0] prog_ticks;
    logic [NTag-1:0]    prog_tag;
    logic               prog_v;
    logic               prog_a;

    logic [NTag-1:0]    out_tag;
    logic [NCt-1:0]     out_ct;
    logic               out_v;
    logic               out_a;

    modport master (
        output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_a,
        input  prog_a, out_tag, out_ct, out_v
    );

    modport slave (
        input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v, out_a,
        output prog_a, out_tag, out_ct, out_v
    );

endinterface

// File: rtl/spike_gen_mem.sv
// Simple dual-port generator table: one write port, one registered read port.
// Contents are deliberately not reset; software programs entries before use.
module spike_gen_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 43
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    // Write port: programming words and sweep write-backs share it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last word when no read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spike_generator_array.sv
// Time-multiplexed array of periodic spike generators. Each time-unit pulse
// triggers a sweep over generators 0..gens_used; every enabled generator whose
// countdown expires emits one tag word, then reloads its countdown.
module spike_generator_array
    import spike_generator_array_pkg::*;
#(
    parameter int NGens   = N_GENS,
    parameter int NPeriod = N_PERIOD,
    parameter int NTag    = N_TAG,
    parameter int NCt     = N_CT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 time_unit_pulse,
    input  logic [NGens-1:0]     gens_used,
    input  logic [2**NGens-1:0]  gens_en,
    output logic                 overrun,
    spike_generator_array_if.slave bus
);

    localparam int EntryW = $bits(gen_entry_t);

    gen_state_t         state, state_next;
    logic [NGens-1:0]   idx, idx_next;
    logic               pending, pending_next;
    logic               overrun_q, overrun_next;
    logic               out_v_q, out_v_next;
    logic [NTag-1:0]    out_tag_q, out_tag_next;

    logic               mem_we, mem_re;
    logic [NGens-1:0]   mem_waddr, mem_raddr;
    gen_entry_t         mem_wdata, rd_entry;
    logic [EntryW-1:0]  mem_rdata;

    logic [NPeriod-1:0] rd_period, rd_ticks;
    logic [NTag-1:0]    rd_tag;
    logic               gen_live, fire, advance, prog_a_c;

    spike_gen_mem #(
        .ADDR_W (NGens),
        .DATA_W (EntryW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && !reset),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign rd_entry  = gen_entry_t'(mem_rdata);
    assign rd_period = rd_entry.period;
    assign rd_ticks  = rd_entry.ticks;
    assign rd_tag    = rd_entry.tag;

    // A generator counts down only when enabled with a non-zero period;
    // countdowns of 0 and 1 both fire, so ticks-1 never wraps.
    assign gen_live = gens_en[idx] && (rd_period != '0);
    assign fire     = gen_live && (rd_ticks <= NPeriod'(1));

    assign bus.prog_a  = prog_a_c;
    assign bus.out_v   = out_v_q;
    assign bus.out_tag = out_tag_q;
    assign bus.out_ct  = NCt'(CT_ONE);
    assign overrun     = overrun_q;

    // Next-state, table access and output decisions for the sweep FSM.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        pending_next = pending;
        overrun_next = overrun_q;
        out_v_next   = out_v_q;
        out_tag_next = out_tag_q;
        mem_we       = 1'b0;
        mem_waddr    = idx;
        mem_wdata    = rd_entry;
        mem_re       = 1'b0;
        mem_raddr    = idx;
        prog_a_c     = 1'b0;
        advance      = 1'b0;

        if (time_unit_pulse) begin
            if (pending) begin
                overrun_next = 1'b1;
            end
            pending_next = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                prog_a_c = bus.prog_v;
                if (bus.prog_v) begin
                    mem_we           = 1'b1;
                    mem_waddr        = bus.prog_gen_idx;
                    mem_wdata.period = bus.prog_period;
                    mem_wdata.ticks  = bus.prog_ticks;
                    mem_wdata.tag    = bus.prog_tag;
                end else if (time_unit_pulse || pending) begin
                    pending_next = 1'b0;
                    idx_next     = '0;
                    mem_re       = 1'b1;
                    mem_raddr    = '0;
                    state_next   = ST_READ;
                end
            end
            ST_READ: begin
                state_next = ST_EVAL;
            end
            ST_EVAL: begin
                if (fire) begin
                    mem_we          = 1'b1;
                    mem_wdata.ticks = rd_period;
                    out_tag_next    = rd_tag;
                    out_v_next      = 1'b1;
                    state_next      = ST_EMIT;
                end else begin
                    if (gen_live) begin
                        mem_we          = 1'b1;
                        mem_wdata.ticks = rd_ticks - NPeriod'(1);
                    end
                    advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (bus.out_a) begin
                    out_v_next = 1'b0;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (idx == gens_used) begin
                state_next = ST_IDLE;
            end else begin
                idx_next   = idx + NGens'(1);
                mem_re     = 1'b1;
                mem_raddr  = idx + NGens'(1);
                state_next = ST_READ;
            end
        end
    end

    // State register; reset abandons any sweep and drops an in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            pending   <= pending_next;
            overrun_q <= overrun_next;
            out_v_q   <= out_v_next;
            out_tag_q <= out_tag_next;
        end
    end

endmodule

// File: tb/tb_spike_generator_array.sv
// Directed self-checking bench for spike_generator_array.
module tb_spike_generator_array;
    import spike_generator_array_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                time_unit_pulse;
    logic [N_GENS-1:0]   gens_used;
    logic [2**N_GENS-1:0] gens_en;
    logic                overrun;

    int checks = 0;
    int errors = 0;

    logic [N_TAG-1:0] word_q[$];
    logic [N_CT-1:0]  ct_q[$];

    int   t1_exp[7]  = '{1, 0, 0, 1, 0, 0, 1};
    int   t2_exp[4]  = '{2, 1, 2, 1};
    int   t5_exp[7]  = '{0, 1, 0, 0, 0, 0, 1};
    logic t5_en[7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic stable;

    spike_generator_array_if bus ();

    spike_generator_array dut (
        .clk             (clk),
        .reset           (reset),
        .time_unit_pulse (time_unit_pulse),
        .gens_used       (gens_used),
        .gens_en         (gens_en),
        .overrun         (overrun),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Record every word that will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (bus.out_v === 1'b1 && bus.out_a === 1'b1) begin
            word_q.push_back(bus.out_tag);
            ct_q.push_back(bus.out_ct);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic checkWords(input string name, input int exp_n,
                              input logic [N_TAG-1:0] e0, input logic [N_TAG-1:0] e1);
        checkOutput({name, "_count"}, word_q.size(), exp_n);
        if (exp_n > 0) begin
            checkOutput({name, "_tag0"}, (word_q.size() > 0) ? word_q[0] : '1, e0);
            checkOutput({name, "_ct0"}, (ct_q.size() > 0) ? ct_q[0] : '0, 1);
        end
        if (exp_n > 1) begin
            checkOutput({name, "_tag1"}, (word_q.size() > 1) ? word_q[1] : '1, e1);
        end
    endtask

    task automatic program_gen(input logic [N_GENS-1:0] gidx, input logic [N_PERIOD-1:0] period,
                               input logic [N_PERIOD-1:0] ticks, input logic [N_TAG-1:0] tag);
        bus.prog_gen_idx = gidx;
        bus.prog_period  = period;
        bus.prog_ticks   = ticks;
        bus.prog_tag     = tag;
        bus.prog_v       = 1'b1;
        #1;
        for (int n = 0; n < 2000 && bus.prog_a !== 1'b1; n++) begin
            step();
        end
        checkOutput("prog_accept", bus.prog_a, 1);
        step();
        bus.prog_v = 1'b0;
    endtask

    // One time-unit pulse, then let the sweep run for a number of cycles.
    task automatic applyStimulus(input int cycles);
        word_q.delete();
        ct_q.delete();
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        reset            = 1'b1;
        time_unit_pulse  = 1'b0;
        gens_used        = '0;
        gens_en          = '0;
        bus.prog_gen_idx = '0;
        bus.prog_period  = '0;
        bus.prog_ticks   = '0;
        bus.prog_tag     = '0;
        bus.prog_v       = 1'b0;
        bus.out_a        = 1'b1;
        repeat (3) step();

        // Reset state
        checkOutput("rst_out_v", bus.out_v, 0);
        checkOutput("rst_prog_a", bus.prog_a, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_out_tag", bus.out_tag, 0);
        checkOutput("rst_out_ct", bus.out_ct, 1);
        reset = 1'b0;
        step();

        // Test 1: period 3, first fire on pulse 1, then every third pulse
        $display("[TB] test 1: single generator, period 3");
        program_gen(8'd0, 16'd3, 16'd1, 11'h02A);
        gens_used  = 8'd0;
        gens_en[0] = 1'b1;
        word_q.delete();
        ct_q.delete();
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        checkOutput("t1_lat_read", bus.out_v, 0);
        step();
        checkOutput("t1_lat_eval", bus.out_v, 0);
        step();
        checkOutput("t1_lat_emit", bus.out_v, 1);
        checkOutput("t1_lat_tag", bus.out_tag, 11'h02A);
        repeat (6) step();
        checkWords("t1_p1", t1_exp[0], 11'h02A, 11'h000);
        for (int p = 1; p < 7; p++) begin
            applyStimulus(8);
            checkWords($sformatf("t1_p%0d", p + 1), t1_exp[p], 11'h02A, 11'h000);
        end

        // Test 2: three generators, periods 1, 2, 0; order by index
        $display("[TB] test 2: three generators");
        program_gen(8'd0, 16'd1, 16'd1, 11'h101);
        program_gen(8'd1, 16'd2, 16'd1, 11'h102);
        program_gen(8'd2, 16'd0, 16'd1, 11'h103);
        gens_used    = 8'd2;
        gens_en[2:0] = 3'b111;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(15);
            checkWords($sformatf("t2_p%0d", p + 1), t2_exp[p], 11'h101, 11'h102);
        end

        // Test 3: backpressure holds the word stable, then one transfer
        $display("[TB] test 3: backpressure");
        program_gen(8'd0, 16'd1, 16'd1, 11'h033);
        gens_used  = 8'd0;
        gens_en    = '0;
        gens_en[0] = 1'b1;
        bus.out_a  = 1'b0;
        word_q.delete();
        ct_q.delete();
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        for (int n = 0; n < 10 && bus.out_v !== 1'b1; n++) step();
        checkOutput("t3_valid", bus.out_v, 1);
        stable = 1'b1;
        repeat (20) begin
            step();
            if (bus.out_v !== 1'b1 || bus.out_tag !== 11'h033) stable = 1'b0;
        end
        checkOutput("t3_hold", stable, 1);
        checkOutput("t3_no_xfer", word_q.size(), 0);
        bus.out_a = 1'b1;
        repeat (10) step();
        checkWords("t3_release", 1, 11'h033, 11'h000);

        // Test 4: back-to-back pulses go pending, third sets overrun
        $display("[TB] test 4: pending and overrun");
        gens_used = 8'd255;
        word_q.delete();
        ct_q.delete();
        time_unit_pulse = 1'b1;
        step();
        step();
        time_unit_pulse = 1'b0;
        checkOutput("t4_no_overrun", overrun, 0);
        repeat (2) step();
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        checkOutput("t4_overrun_set", overrun, 1);
        repeat (1200) step();
        checkWords("t4_sweeps", 2, 11'h033, 11'h033);
        checkOutput("t4_overrun_sticky", overrun, 1);

        // Test 5: programming blocked during a sweep, then lands in IDLE
        $display("[TB] test 5: programming during sweep, enable freeze");
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse  = 1'b0;
        bus.prog_gen_idx = 8'd0;
        bus.prog_period  = 16'd3;
        bus.prog_ticks   = 16'd2;
        bus.prog_tag     = 11'h155;
        bus.prog_v       = 1'b1;
        #1;
        checkOutput("t5_blocked_early", bus.prog_a, 0);
        repeat (100) step();
        checkOutput("t5_blocked_mid", bus.prog_a, 0);
        for (int n = 0; n < 1000 && bus.prog_a !== 1'b1; n++) step();
        checkOutput("t5_accept_idle", bus.prog_a, 1);
        step();
        bus.prog_v = 1'b0;
        gens_used  = 8'd0;
        for (int p = 0; p < 7; p++) begin
            gens_en[0] = t5_en[p];
            applyStimulus(8);
            checkWords($sformatf("t5_p%0d", p + 1), t5_exp[p], 11'h155, 11'h000);
        end
        gens_en[0] = 1'b1;

        // Test 6: reset while emitting drops the word; sweep restarts at 0
        $display("[TB] test 6: reset during emit");
        program_gen(8'd0, 16'd1, 16'd1, 11'h0AA);
        bus.out_a = 1'b0;
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        for (int n = 0; n < 10 && bus.out_v !== 1'b1; n++) step();
        checkOutput("t6_in_emit", bus.out_v, 1);
        reset            = 1'b1;
        bus.prog_gen_idx = 8'd7;
        bus.prog_period  = 16'd0;
        bus.prog_ticks   = 16'd0;
        bus.prog_tag     = 11'h077;
        bus.prog_v       = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t6_out_v_dropped", bus.out_v, 0);
        checkOutput("t6_idle", bus.prog_a, 1);
        checkOutput("t6_overrun_cleared", overrun, 0);
        checkOutput("t6_out_tag_reset", bus.out_tag, 0);
        step();
        bus.prog_v = 1'b0;
        bus.out_a  = 1'b1;
        word_q.delete();
        ct_q.delete();
        time_unit_pulse = 1'b1;
        step();
        time_unit_pulse = 1'b0;
        checkOutput("t6_lat_read", bus.out_v, 0);
        step();
        checkOutput("t6_lat_eval", bus.out_v, 0);
        step();
        checkOutput("t6_lat_emit", bus.out_v, 1);
        checkOutput("t6_lat_tag", bus.out_tag, 11'h0AA);
        repeat (5) step();
        checkWords("t6_restart", 1, 11'h0AA, 11'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
